// File: rtl/div_arbiter_pkg.sv
// Shared types and defaults for the two-requester divider arbiter.
package div_arbiter_pkg;

   localparam int DIV_WIDTH      = 32;
   localparam int DIV_WAIT_LIMIT = 64;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_IO  = 1'b1
   } owner_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester (CPU r0, IO r1) and divider-side signals of div_arbiter.
// master = arbiter side, slave = requesters plus divider.
interface div_arbiter_if
   import div_arbiter_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic             r0_req;
   logic [WIDTH-1:0] r0_a;
   logic [WIDTH-1:0] r0_b;
   logic             r0_signed;
   logic             r0_rem;
   logic             r0_flush;
   logic             r0_done;
   logic [WIDTH-1:0] r0_result;
   logic             r0_err;

   logic             r1_req;
   logic [WIDTH-1:0] r1_a;
   logic [WIDTH-1:0] r1_b;
   logic             r1_signed;
   logic             r1_rem;
   logic             r1_done;
   logic [WIDTH-1:0] r1_result;
   logic             r1_err;

   logic             div_write_a;
   logic             div_start;
   logic [WIDTH-1:0] div_a;
   logic [WIDTH-1:0] div_b;
   logic             div_signed;
   logic             div_flush;
   logic             div_ready;
   logic [WIDTH-1:0] div_quotient;
   logic [WIDTH-1:0] div_remainder;
   logic             busy;

   modport master (
      input  r0_req, r0_a, r0_b, r0_signed, r0_rem, r0_flush,
      input  r1_req, r1_a, r1_b, r1_signed, r1_rem,
      input  div_ready, div_quotient, div_remainder,
      output r0_done, r0_result, r0_err, r1_done, r1_result, r1_err,
      output div_write_a, div_start, div_a, div_b, div_signed, div_flush, busy
   );

   modport slave (
      output r0_req, r0_a, r0_b, r0_signed, r0_rem, r0_flush,
      output r1_req, r1_a, r1_b, r1_signed, r1_rem,
      output div_ready, div_quotient, div_remainder,
      input  r0_done, r0_result, r0_err, r1_done, r1_result, r1_err,
      input  div_write_a, div_start, div_a, div_b, div_signed, div_flush, busy
   );

endinterface

// File: rtl/div_arbiter_rr.sv
// Two-way round-robin grant; after reset the last grant reads as IO so the CPU wins the first tie.
module div_arbiter_rr
   import div_arbiter_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en,
   input  logic   req0,
   input  logic   req1,
   output logic   gnt_valid,
   output owner_t gnt_id
);
   owner_t last_r;

   // Grant decision: on a tie the requester not granted last time wins
   always_comb begin
      gnt_valid = en & (req0 | req1);
      gnt_id    = REQ_CPU;
      if (req0 && req1) begin
         gnt_id = (last_r == REQ_CPU) ? REQ_IO : REQ_CPU;
      end else if (req1) begin
         gnt_id = REQ_IO;
      end else begin
         gnt_id = REQ_CPU;
      end
   end

   // Remember the most recent grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r <= REQ_IO;
      end else if (gnt_valid) begin
         last_r <= gnt_id;
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider between CPU (r0) and IO (r1): write_a, start, wait for ready, respond.
// Optional build macro DIVARB_ZERO_BYPASS_EN answers zero-divisor requests without the divider.
module div_arbiter
   import div_arbiter_pkg::*;
#(
   parameter int WIDTH      = DIV_WIDTH,
   parameter int WAIT_LIMIT = DIV_WAIT_LIMIT
) (
   input logic           clk,
   input logic           rst_n,
   div_arbiter_if.master bus
);
   localparam int CW = $clog2(WAIT_LIMIT + 1);

   state_t           state_r, state_nxt_s;
   owner_t           owner_r, owner_nxt_s, gnt_id_s;
   logic             gnt_valid_s;
   logic [WIDTH-1:0] a_r, b_r, a_nxt_s, b_nxt_s, res_nxt_s;
   logic             signed_r, rem_r, signed_nxt_s, rem_nxt_s;
   logic [CW-1:0]    cnt_r, cnt_nxt_s;
   logic             flush_hit_s, finish_s, err_nxt_s, flush_nxt_s, op_active_s;

   div_arbiter_rr u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state_r == IDLE),
      .req0      (bus.r0_req & ~bus.r0_flush),
      .req1      (bus.r1_req),
      .gnt_valid (gnt_valid_s),
      .gnt_id    (gnt_id_s)
   );

   assign flush_hit_s = (owner_r == REQ_CPU) && bus.r0_flush;
   assign op_active_s = (state_nxt_s == LOAD_A) || (state_nxt_s == START) || (state_nxt_s == WAIT);

   // Snapshot the winning requester's operands at grant time
   always_comb begin
      a_nxt_s      = a_r;
      b_nxt_s      = b_r;
      signed_nxt_s = signed_r;
      rem_nxt_s    = rem_r;
      owner_nxt_s  = owner_r;
      if (gnt_valid_s) begin
         owner_nxt_s = gnt_id_s;
         if (gnt_id_s == REQ_IO) begin
            a_nxt_s      = bus.r1_a;
            b_nxt_s      = bus.r1_b;
            signed_nxt_s = bus.r1_signed;
            rem_nxt_s    = bus.r1_rem;
         end else begin
            a_nxt_s      = bus.r0_a;
            b_nxt_s      = bus.r0_b;
            signed_nxt_s = bus.r0_signed;
            rem_nxt_s    = bus.r0_rem;
         end
      end else begin
         owner_nxt_s = owner_r;
      end
   end

   // Divider sequencing; flush beats ready, ready beats timeout
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      finish_s    = 1'b0;
      err_nxt_s   = 1'b0;
      flush_nxt_s = 1'b0;
      res_nxt_s   = '0;
      case (state_r)
         IDLE: begin
            if (gnt_valid_s) begin
`ifdef DIVARB_ZERO_BYPASS_EN
               if (b_nxt_s == '0) begin
                  state_nxt_s = RESP;
                  finish_s    = 1'b1;
                  res_nxt_s   = rem_nxt_s ? a_nxt_s : '1;
               end else begin
                  state_nxt_s = LOAD_A;
               end
`else
               state_nxt_s = LOAD_A;
`endif
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD_A: begin
            if (flush_hit_s) begin
               state_nxt_s = IDLE;
               flush_nxt_s = 1'b1;
            end else begin
               state_nxt_s = START;
            end
         end
         START: begin
            if (flush_hit_s) begin
               state_nxt_s = IDLE;
               flush_nxt_s = 1'b1;
            end else begin
               state_nxt_s = WAIT;
               cnt_nxt_s   = '0;
            end
         end
         WAIT: begin
            if (flush_hit_s) begin
               state_nxt_s = IDLE;
               flush_nxt_s = 1'b1;
            end else if (bus.div_ready) begin
               state_nxt_s = RESP;
               finish_s    = 1'b1;
               res_nxt_s   = rem_r ? bus.div_remainder : bus.div_quotient;
            end else if (cnt_r == CW'(WAIT_LIMIT - 1)) begin
               state_nxt_s = RESP;
               finish_s    = 1'b1;
               err_nxt_s   = 1'b1;
               flush_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, captured request and WAIT counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         owner_r  <= REQ_CPU;
         a_r      <= '0;
         b_r      <= '0;
         signed_r <= 1'b0;
         rem_r    <= 1'b0;
         cnt_r    <= '0;
      end else begin
         state_r  <= state_nxt_s;
         owner_r  <= owner_nxt_s;
         a_r      <= a_nxt_s;
         b_r      <= b_nxt_s;
         signed_r <= signed_nxt_s;
         rem_r    <= rem_nxt_s;
         cnt_r    <= cnt_nxt_s;
      end
   end

   // Outputs registered from the next state so each matches the state it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.div_write_a <= 1'b0;
         bus.div_start   <= 1'b0;
         bus.div_a       <= '0;
         bus.div_b       <= '0;
         bus.div_signed  <= 1'b0;
         bus.div_flush   <= 1'b0;
         bus.busy        <= 1'b0;
         bus.r0_done     <= 1'b0;
         bus.r0_result   <= '0;
         bus.r0_err      <= 1'b0;
         bus.r1_done     <= 1'b0;
         bus.r1_result   <= '0;
         bus.r1_err      <= 1'b0;
      end else begin
         bus.div_write_a <= (state_nxt_s == LOAD_A);
         bus.div_start   <= (state_nxt_s == START);
         bus.div_a       <= op_active_s ? a_nxt_s : '0;
         bus.div_b       <= op_active_s ? b_nxt_s : '0;
         bus.div_signed  <= op_active_s & signed_nxt_s;
         bus.div_flush   <= flush_nxt_s;
         bus.busy        <= (state_nxt_s != IDLE);
         bus.r0_done     <= finish_s && (owner_nxt_s == REQ_CPU);
         bus.r1_done     <= finish_s && (owner_nxt_s == REQ_IO);
         if (finish_s && (owner_nxt_s == REQ_CPU)) begin
            bus.r0_result <= res_nxt_s;
            bus.r0_err    <= err_nxt_s;
         end
         if (finish_s && (owner_nxt_s == REQ_IO)) begin
            bus.r1_result <= res_nxt_s;
            bus.r1_err    <= err_nxt_s;
         end
      end
   end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomised self-checking bench for div_arbiter with a behavioural divider and arithmetic reference.
module tb_div_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   last_served = 1;
   int   div_dly = 6;
   logic [31:0] res0 = 32'd0;
   logic [31:0] res1 = 32'd0;

   div_arbiter_if #(.WIDTH(32)) bus ();

   div_arbiter #(.WIDTH(32), .WAIT_LIMIT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input bit sg, input bit rem);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (sg) return rem ? 32'(sa % sb) : 32'(sa / sb);
      return rem ? a % b : a / b;
   endfunction

   // Divider stand-in: answers div_dly cycles after start (never when div_dly < 0)
   int mdl_cnt = -1;
   logic [31:0] mdl_a = 32'd0, mdl_b = 32'd0;
   bit mdl_s = 1'b0;
   always @(negedge clk) begin
      bus.div_ready = 1'b0;
      if (!rst_n || bus.div_flush) begin
         mdl_cnt = -1;
      end else begin
         if (bus.div_write_a) mdl_a = bus.div_a;
         if (bus.div_start) begin
            mdl_b   = bus.div_b;
            mdl_s   = bus.div_signed;
            mdl_cnt = div_dly;
         end else if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0) begin
               bus.div_ready     = 1'b1;
               bus.div_quotient  = ref_div(mdl_a, mdl_b, mdl_s, 1'b0);
               bus.div_remainder = ref_div(mdl_a, mdl_b, mdl_s, 1'b1);
               mdl_cnt = -1;
            end
         end
      end
   end

   task automatic do_pair(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                          input bit s0, input bit m0,
                          input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                          input bit s1, input bit m1);
      logic [31:0] e0, e1;
      bit p0, p1;
      int first, served;
      e0 = ref_div(a0, b0, s0, m0);
      e1 = ref_div(a1, b1, s1, m1);
      first = (v0 && v1) ? ((last_served == 0) ? 1 : 0) : (v0 ? 0 : 1);
      @(negedge clk);
      bus.r0_a = a0; bus.r0_b = b0; bus.r0_signed = s0; bus.r0_rem = m0; bus.r0_req = v0;
      bus.r1_a = a1; bus.r1_b = b1; bus.r1_signed = s1; bus.r1_rem = m1; bus.r1_req = v1;
      p0 = v0; p1 = v1; served = 0;
      for (int n = 0; n < 400 && (p0 || p1); n++) begin
         @(negedge clk);
         if (bus.r0_done === 1'b1) begin
            checks++;
            if (!p0 || bus.r0_result !== e0 || bus.r0_err !== 1'b0
                || (served == 0 && first != 0) || bus.r1_result !== res1) begin
               failures++;
               $display("FAIL r0_done: pending=%0b result=%h err=%0b first=%0d r1_result=%h (want result %h err 0 r1_result %h)",
                        p0, bus.r0_result, bus.r0_err, first, bus.r1_result, e0, res1);
            end
            res0 = e0; p0 = 1'b0; bus.r0_req = 1'b0; served++; last_served = 0;
         end
         if (bus.r1_done === 1'b1) begin
            checks++;
            if (!p1 || bus.r1_result !== e1 || bus.r1_err !== 1'b0
                || (served == 0 && first != 1) || bus.r0_result !== res0) begin
               failures++;
               $display("FAIL r1_done: pending=%0b result=%h err=%0b first=%0d r0_result=%h (want result %h err 0 r0_result %h)",
                        p1, bus.r1_result, bus.r1_err, first, bus.r0_result, e1, res0);
            end
            res1 = e1; p1 = 1'b0; bus.r1_req = 1'b0; served++; last_served = 1;
         end
      end
      checks++;
      if (p0 || p1) begin
         failures++;
         $display("FAIL pair_timeout: still pending r0=%0b r1=%0b (want both served)", p0, p1);
      end
   endtask

   task automatic check_idle_zero(input string name);
      checks++;
      if ({bus.busy, bus.div_write_a, bus.div_start, bus.div_flush, bus.div_signed,
           bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err} !== 9'd0
          || bus.div_a !== 32'd0 || bus.div_b !== 32'd0
          || bus.r0_result !== 32'd0 || bus.r1_result !== 32'd0) begin
         failures++;
         $display("FAIL %s: flags=%b div_a=%h div_b=%h r0_result=%h r1_result=%h (want all zero)", name,
                  {bus.busy, bus.div_write_a, bus.div_start, bus.div_flush, bus.div_signed,
                   bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err},
                  bus.div_a, bus.div_b, bus.r0_result, bus.r1_result);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_idle_zero("reset_hold");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_zero("reset_release");
   endtask

   task automatic test_tie();
      div_dly = 7;
      do_pair(1'b1, 32'd17, 32'd3, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      checks++;
      if (res0 !== 32'd2 || res1 !== 32'hFFFF_FFFD) begin
         failures++;
         $display("FAIL tie_values: r0=%h r1=%h (want 2 fffffffd)", res0, res1);
      end
      div_dly = 3;
      do_pair(1'b1, 32'd100, 32'd10, 1'b0, 1'b0, 1'b1, 32'd33, 32'd4, 1'b0, 1'b1);
   endtask

   task automatic test_latency();
      int done_at;
      div_dly = 20;
      done_at = -1;
      @(negedge clk);
      bus.r0_a = 32'd17; bus.r0_b = 32'd3; bus.r0_signed = 1'b0; bus.r0_rem = 1'b0; bus.r0_req = 1'b1;
      for (int n = 1; n <= 40 && done_at < 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            checks++;
            if (bus.div_write_a !== 1'b1 || bus.div_start !== 1'b0 || bus.div_a !== 32'd17) begin
               failures++;
               $display("FAIL load_a: write_a=%0b start=%0b div_a=%0d (want 1 0 17)",
                        bus.div_write_a, bus.div_start, bus.div_a);
            end
         end
         if (n == 2) begin
            checks++;
            if (bus.div_write_a !== 1'b0 || bus.div_start !== 1'b1 || bus.div_b !== 32'd3
                || bus.div_a !== 32'd17) begin
               failures++;
               $display("FAIL start: write_a=%0b start=%0b div_a=%0d div_b=%0d (want 0 1 17 3)",
                        bus.div_write_a, bus.div_start, bus.div_a, bus.div_b);
            end
         end
         if (bus.r0_done === 1'b1) begin
            done_at = n;
            bus.r0_req = 1'b0;
         end
      end
      checks++;
      if (done_at != 23 || bus.r0_result !== 32'd5 || bus.r0_err !== 1'b0 || bus.r1_result !== res1) begin
         failures++;
         $display("FAIL latency: done_cycle=%0d result=%0d err=%0b (want 23 5 0)",
                  done_at, bus.r0_result, bus.r0_err);
      end
      res0 = 32'd5; last_served = 0;
   endtask

   task automatic test_flush_wait();
      int r1_seen;
      div_dly = -1;
      r1_seen = 0;
      @(negedge clk);
      bus.r0_a = 32'd100; bus.r0_b = 32'd7; bus.r0_signed = 1'b0; bus.r0_rem = 1'b0; bus.r0_req = 1'b1;
      @(negedge clk);
      bus.r1_a = 32'd50; bus.r1_b = 32'd5; bus.r1_signed = 1'b0; bus.r1_rem = 1'b0; bus.r1_req = 1'b1;
      repeat (8) @(negedge clk);
      bus.r0_flush = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.div_flush !== 1'b1 || bus.busy !== 1'b0 || bus.r0_done !== 1'b0) begin
         failures++;
         $display("FAIL flush_wait: div_flush=%0b busy=%0b r0_done=%0b (want 1 0 0)",
                  bus.div_flush, bus.busy, bus.r0_done);
      end
      bus.r0_flush = 1'b0; bus.r0_req = 1'b0; div_dly = 4;
      @(negedge clk);
      checks++;
      if (bus.div_flush !== 1'b0) begin
         failures++;
         $display("FAIL flush_pulse_width: div_flush=%0b (want 0)", bus.div_flush);
      end
      for (int n = 0; n < 100 && r1_seen == 0; n++) begin
         @(negedge clk);
         if (bus.r0_done === 1'b1) begin
            checks++; failures++;
            $display("FAIL flushed_done: r0_done=1 (want 0)");
         end
         if (bus.r1_done === 1'b1) begin
            r1_seen = 1; bus.r1_req = 1'b0;
         end
      end
      checks++;
      if (r1_seen == 0 || bus.r1_result !== 32'd10 || bus.r0_result !== res0) begin
         failures++;
         $display("FAIL flush_then_r1: seen=%0d r1_result=%0d r0_result=%h (want 1 10 %h)",
                  r1_seen, bus.r1_result, bus.r0_result, res0);
      end
      res1 = 32'd10; last_served = 1;
   endtask

   task automatic test_flush_ignored();
      int seen;
      div_dly = 15;
      seen = 0;
      @(negedge clk);
      bus.r1_a = 32'd91; bus.r1_b = 32'd4; bus.r1_signed = 1'b0; bus.r1_rem = 1'b1; bus.r1_req = 1'b1;
      for (int n = 1; n < 60 && seen == 0; n++) begin
         @(negedge clk);
         bus.r0_flush = (n >= 5 && n <= 8);
         if (bus.div_flush === 1'b1) begin
            checks++; failures++;
            $display("FAIL flush_ignored: div_flush=1 while r1 owns (want 0)");
         end
         if (bus.r1_done === 1'b1) begin
            seen = 1; bus.r1_req = 1'b0;
         end
      end
      bus.r0_flush = 1'b0;
      checks++;
      if (seen == 0 || bus.r1_result !== 32'd3 || bus.r1_err !== 1'b0) begin
         failures++;
         $display("FAIL flush_ignored_result: seen=%0d result=%0d err=%0b (want 1 3 0)",
                  seen, bus.r1_result, bus.r1_err);
      end
      res1 = 32'd3; last_served = 1;
   endtask

   task automatic test_flush_idle();
      @(negedge clk);
      bus.r0_flush = 1'b1;
      bus.r0_a = 32'd64; bus.r0_b = 32'd8; bus.r0_signed = 1'b0; bus.r0_rem = 1'b0; bus.r0_req = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b0 || bus.div_write_a !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: busy=%0b write_a=%0b (want 0 0)", bus.busy, bus.div_write_a);
         end
      end
      bus.r0_flush = 1'b0;
      bus.r0_req = 1'b0;
      div_dly = 3;
      do_pair(1'b1, 32'd64, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      int st, dn;
      logic fl, er;
      logic [31:0] rs;
      div_dly = -1;
      st = -1; dn = -1; fl = 1'b0; er = 1'b0; rs = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.r0_a = 32'd200; bus.r0_b = 32'd9; bus.r0_signed = 1'b0; bus.r0_rem = 1'b0; bus.r0_req = 1'b1;
      for (int n = 1; n < 150 && dn < 0; n++) begin
         @(negedge clk);
         if (bus.div_start === 1'b1) st = n;
         if (bus.r0_done === 1'b1) begin
            dn = n; fl = bus.div_flush; er = bus.r0_err; rs = bus.r0_result;
            bus.r0_req = 1'b0;
         end
      end
      checks++;
      if (dn < 0 || st < 0 || dn - st != 65 || er !== 1'b1 || rs !== 32'd0 || fl !== 1'b1) begin
         failures++;
         $display("FAIL timeout: start=%0d done=%0d err=%0b result=%h div_flush=%0b (want done-start 65 err 1 result 0 flush 1)",
                  st, dn, er, rs, fl);
      end
      @(negedge clk);
      checks++;
      if (bus.div_flush !== 1'b0) begin
         failures++;
         $display("FAIL timeout_flush_width: div_flush=%0b (want 0)", bus.div_flush);
      end
      res0 = 32'd0; last_served = 0;
   endtask

   task automatic test_zero_div();
`ifdef DIVARB_ZERO_BYPASS_EN
      for (int k = 0; k < 2; k++) begin
         int dn;
         bit pulsed;
         logic [31:0] want;
         dn = -1; pulsed = 1'b0;
         want = (k == 1) ? 32'd9 : 32'hFFFF_FFFF;
         @(negedge clk);
         bus.r1_a = 32'd9; bus.r1_b = 32'd0; bus.r1_signed = 1'b0; bus.r1_rem = (k == 1); bus.r1_req = 1'b1;
         for (int n = 1; n < 10 && dn < 0; n++) begin
            @(negedge clk);
            if (bus.div_write_a === 1'b1 || bus.div_start === 1'b1) pulsed = 1'b1;
            if (bus.r1_done === 1'b1) begin
               dn = n; bus.r1_req = 1'b0;
            end
         end
         checks++;
         if (dn != 1 || pulsed || bus.r1_result !== want || bus.r1_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_bypass: done_cycle=%0d pulses=%0b result=%h err=%0b (want 1 0 %h 0)",
                     dn, pulsed, bus.r1_result, bus.r1_err, want);
         end
         res1 = want; last_served = 1;
      end
`else
      div_dly = 5;
      do_pair(1'b0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1, 32'd9, 32'd0, 1'b0, 1'b0);
      do_pair(1'b0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1, 32'd9, 32'd0, 1'b0, 1'b1);
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         bit v0, v1, s0, s1, m0, m1;
         logic [31:0] a0, b0, a1, b1;
         v0 = $urandom_range(0, 1); v1 = $urandom_range(0, 1);
         if (!v0 && !v1) v0 = 1'b1;
         s0 = $urandom_range(0, 1); s1 = $urandom_range(0, 1);
         m0 = $urandom_range(0, 1); m1 = $urandom_range(0, 1);
         a0 = $urandom; a1 = $urandom;
         b0 = $urandom_range(1, 1000); b1 = $urandom_range(1, 1000);
         if ($urandom_range(0, 1) == 1) b0 = -b0;
         if ($urandom_range(0, 7) == 0) b1 = 32'd0;
         if (b0 == 32'hFFFF_FFFF) b0 = 32'd3;
         div_dly = $urandom_range(1, 30);
         do_pair(v0, a0, b0, s0, m0, v1, a1, b1, s1, m1);
      end
   endtask

   task automatic test_reset_mid();
      bit spurious;
      spurious = 1'b0;
      div_dly = -1;
      @(negedge clk);
      bus.r0_a = 32'd40; bus.r0_b = 32'd5; bus.r0_signed = 1'b0; bus.r0_rem = 1'b0; bus.r0_req = 1'b1;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_zero("reset_mid");
      @(negedge clk);
      bus.r0_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (bus.r0_done === 1'b1 || bus.r1_done === 1'b1) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         failures++;
         $display("FAIL reset_no_done: done pulse seen after reset (want none)");
      end
      res0 = 32'd0; res1 = 32'd0; last_served = 1;
      div_dly = 5;
      do_pair(1'b1, 32'd81, 32'd9, 1'b0, 1'b0, 1'b1, 32'd77, 32'd10, 1'b0, 1'b1);
   endtask

   initial begin
      bus.r0_req = 1'b0; bus.r0_a = 32'd0; bus.r0_b = 32'd0; bus.r0_signed = 1'b0;
      bus.r0_rem = 1'b0; bus.r0_flush = 1'b0;
      bus.r1_req = 1'b0; bus.r1_a = 32'd0; bus.r1_b = 32'd0; bus.r1_signed = 1'b0; bus.r1_rem = 1'b0;
      bus.div_ready = 1'b0; bus.div_quotient = 32'd0; bus.div_remainder = 32'd0;
      test_reset();
      test_tie();
      test_latency();
      test_flush_wait();
      test_flush_ignored();
      test_flush_idle();
      test_timeout();
      test_zero_div();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
